br_redirect_ctrl: RTL
=====================

BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32): PC/target width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of each performance counter.
REQ-003 SHALL have parameter HOLD_MAX, default 15: maximum HOLD cycles before hold_err_o asserts.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port br_valid_i, input, 1: the ID stage holds a branch or jump.
REQ-007 SHALL have port jump_i, input, 1: the instruction is JAL/JALR, so it is taken unconditionally.
REQ-008 SHALL have port branch_i, input, 1: the branch-unit taken flag.
REQ-009 SHALL have port brj_pc_i, input, DATA_WIDTH: the branch-unit target, already word-aligned.
REQ-010 SHALL have port operand_hazard_i, input, 1: rs1/rs2 are not yet available (load in EX).
REQ-011 SHALL have port fetch_ready_i, input, 1: fetch accepts the redirect this cycle.
REQ-012 SHALL have port redirect_valid_o, output, 1: redirect request to fetch.
REQ-013 SHALL have port redirect_pc_o, output, DATA_WIDTH: registered redirect target.
REQ-014 SHALL have port flush_if_o, output, 1: squash the IF/ID wrong-path instruction.
REQ-015 SHALL have port stall_id_o, output, 1: hold the ID stage and PC.
REQ-016 SHALL have port hold_err_o, output, 1: sticky flag, set when a hazard wait exceeds HOLD_MAX.
REQ-017 SHALL have ports br_total_cnt_o and br_taken_cnt_o, output, CNT_WIDTH: resolved branch/jump count and taken count.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, HOLD, REDIR, SQUASH.
REQ-019 SHALL "resolve" a branch in IDLE or HOLD when br_valid_i=1 and operand_hazard_i=0; taken = jump_i | branch_i, and jump_i dominates.
REQ-020 IDLE, br_valid_i=1 and operand_hazard_i=1 -> HOLD; stall_id_o=1 combinationally in that same cycle.
REQ-021 IDLE or HOLD, resolved taken -> REDIR; redirect_pc_o <= brj_pc_i on that edge; stall_id_o=1 in the resolve cycle.
REQ-022 IDLE or HOLD, resolved not-taken -> IDLE; no stall, no redirect.
REQ-023 HOLD: stall_id_o=1 while operand_hazard_i=1; the hold counter increments each cycle and saturates at HOLD_MAX+1.
REQ-024 HOLD: when the hold counter reaches HOLD_MAX+1, hold_err_o SHALL set; the FSM keeps waiting and hold_err_o stays set until reset.
REQ-025 HOLD: if br_valid_i drops, the FSM SHALL return to IDLE with no count and no redirect.
REQ-026 REDIR: redirect_valid_o=1 and stall_id_o=1; redirect_pc_o SHALL be stable until accepted; fetch_ready_i=1 -> SQUASH.
REQ-027 REDIR: br_valid_i, branch_i, jump_i and brj_pc_i SHALL be ignored.
REQ-028 SQUASH: flush_if_o=1 for exactly one cycle, stall_id_o=0, then -> IDLE; br_valid_i is ignored in SQUASH.
REQ-029 Latency: resolve in cycle N -> redirect_valid_o=1 in N+1; with fetch_ready_i=1 in N+1, flush_if_o=1 in N+2.
REQ-030 br_total_cnt_o SHALL increment once per resolve; br_taken_cnt_o SHALL increment once per taken resolve.
REQ-031 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-032 flush_if_o and redirect_valid_o SHALL never be high in the same cycle.

Reset
REQ-033 rst_i high, asynchronously: state=IDLE; redirect_valid_o=0; redirect_pc_o=0; flush_if_o=0; stall_id_o=0; hold_err_o=0; both counters=0; hold counter=0.
REQ-034 Reset asserted in REDIR or SQUASH SHALL abort the redirect; no flush follows reset deassertion.

Structure
REQ-035 FSM state encodings and the CNT_WIDTH default SHALL live in the shared defines.vh, next to the `BR_* opcodes.
REQ-036 SHALL instantiate sub-module br_perf_cnt (CNT_WIDTH, enable, wrap) twice, once for each performance counter.
REQ-037 stall_id_o and flush_if_o SHALL be decoded from state plus inputs; redirect_pc_o and the counters SHALL be registered.

Verification
REQ-038 br_valid_i=1, branch_i=1, brj_pc_i=0x0000_0100, fetch_ready_i=1 -> redirect_valid_o in N+1 with pc 0x100, flush_if_o in N+2; taken=1, total=1.
REQ-039 br_valid_i=1, branch_i=0, jump_i=0 -> no stall, no redirect; total=1, taken=0.
REQ-040 operand_hazard_i=1 for 3 cycles with jump_i=1 -> stall_id_o=1 for 4 cycles, redirect in the following cycle, hold_err_o=0.
REQ-041 fetch_ready_i=0 for 5 cycles in REDIR while brj_pc_i changes -> redirect_pc_o holds its latched value; exactly one flush after acceptance.
REQ-042 HOLD_MAX=15 with hazard held 20 cycles -> hold_err_o=1 from hold cycle 16; it survives leaving HOLD and clears only on rst_i.
REQ-043 Counters preset to 2^32-1 plus one taken branch -> both wrap to 0; rst_i pulse in REDIR -> all outputs 0 immediately.

Source files
------------

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: default widths,
// FSM state encodings and the taken-decision helper.
package br_redirect_ctrl_pkg;

    // Default PC/target width and performance-counter width.
    localparam int BR_DATA_WIDTH = 32;
    localparam int BR_CNT_WIDTH  = 32;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REDIR  = 2'd2,
        ST_SQUASH = 2'd3
    } br_state_e;

    // A jump is always taken; otherwise the branch unit decides.
    function automatic logic br_taken(input logic jump, input logic branch);
        return jump | branch;
    endfunction

endpackage

// File: rtl/br_redirect_ctrl_if.sv
// ID-stage / fetch handshake bundle for the branch redirect controller.
// master drives the branch and fetch inputs; slave is the controller.
import br_redirect_ctrl_pkg::*;

interface br_redirect_ctrl_if #(
    parameter int DATA_WIDTH = BR_DATA_WIDTH,
    parameter int CNT_WIDTH  = BR_CNT_WIDTH
);
    logic                  br_valid_i;
    logic                  jump_i;
    logic                  branch_i;
    logic [DATA_WIDTH-1:0] brj_pc_i;
    logic                  operand_hazard_i;
    logic                  fetch_ready_i;
    logic                  redirect_valid_o;
    logic [DATA_WIDTH-1:0] redirect_pc_o;
    logic                  flush_if_o;
    logic                  stall_id_o;
    logic                  hold_err_o;
    logic [CNT_WIDTH-1:0]  br_total_cnt_o;
    logic [CNT_WIDTH-1:0]  br_taken_cnt_o;

    modport master (
        output br_valid_i, jump_i, branch_i, brj_pc_i, operand_hazard_i, fetch_ready_i,
        input  redirect_valid_o, redirect_pc_o, flush_if_o, stall_id_o, hold_err_o,
        input  br_total_cnt_o, br_taken_cnt_o
    );

    modport slave (
        input  br_valid_i, jump_i, branch_i, brj_pc_i, operand_hazard_i, fetch_ready_i,
        output redirect_valid_o, redirect_pc_o, flush_if_o, stall_id_o, hold_err_o,
        output br_total_cnt_o, br_taken_cnt_o
    );
endinterface

// File: rtl/br_perf_cnt.sv
// Free-running event counter: increments on en_i, wraps modulo 2^CNT_WIDTH.
module br_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Count enabled events; natural overflow gives the wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = cnt_reg;
endmodule

// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller: resolves ID-stage branches/jumps, waits out
// operand hazards, issues a registered redirect to fetch, then squashes the
// wrong-path IF/ID instruction for one cycle. Keeps resolve/taken counters.
import br_redirect_ctrl_pkg::*;

module br_redirect_ctrl #(
    parameter int DATA_WIDTH = BR_DATA_WIDTH,
    parameter int CNT_WIDTH  = BR_CNT_WIDTH,
    parameter int HOLD_MAX   = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    br_redirect_ctrl_if.slave bus
);
    // Hold counter counts hazard wait cycles (including the IDLE cycle that
    // first saw the hazard) and saturates at HOLD_MAX+1.
    localparam int                   HOLD_CW  = $clog2(HOLD_MAX + 2);
    localparam logic [HOLD_CW-1:0]   HOLD_LIM = HOLD_CW'(HOLD_MAX + 1);

    br_state_e              state_reg, state_next;
    logic [HOLD_CW-1:0]     hold_cnt_reg, hold_cnt_next;
    logic                   hold_err_reg, hold_err_next;
    logic [DATA_WIDTH-1:0]  redirect_pc_reg;

    logic                   taken;
    logic                   resolve;
    logic                   hazard_wait;
    logic                   stall_id;
    logic                   flush_if;
    logic                   redirect_valid;

    logic [1:0]             cnt_en;
    logic [CNT_WIDTH-1:0]   cnt_val [2];

    assign taken = br_taken(bus.jump_i, bus.branch_i);

    // Next-state and decoded outputs; hazard waits bump the hold counter.
    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = '0;
        hold_err_next  = hold_err_reg;
        resolve        = 1'b0;
        hazard_wait    = 1'b0;
        stall_id       = 1'b0;
        flush_if       = 1'b0;
        redirect_valid = 1'b0;

        case (state_reg)
            ST_IDLE, ST_HOLD: begin
                if (!bus.br_valid_i) begin
                    state_next = ST_IDLE;
                end else if (bus.operand_hazard_i) begin
                    hazard_wait = 1'b1;
                    stall_id    = 1'b1;
                    state_next  = ST_HOLD;
                end else begin
                    resolve = 1'b1;
                    if (taken) begin
                        stall_id   = 1'b1;
                        state_next = ST_REDIR;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                stall_id       = 1'b1;
                if (bus.fetch_ready_i) begin
                    state_next = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                flush_if   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (hazard_wait) begin
            hold_cnt_next = (hold_cnt_reg == HOLD_LIM) ? HOLD_LIM : hold_cnt_reg + HOLD_CW'(1);
            if (hold_cnt_next == HOLD_LIM) begin
                hold_err_next = 1'b1;
            end
        end
    end

    // State, hold counter and sticky hold error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            hold_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            hold_err_reg <= hold_err_next;
        end
    end

    // Latch the target on a taken resolve; held steady through REDIR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_pc_reg <= '0;
        end else if (resolve && taken) begin
            redirect_pc_reg <= bus.brj_pc_i;
        end
    end

    // Slot 0 counts every resolve, slot 1 only taken resolves.
    assign cnt_en[0] = resolve;
    assign cnt_en[1] = resolve & taken;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            br_perf_cnt #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (cnt_en[gi]),
                .cnt_o (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_pc_reg;
    assign bus.flush_if_o       = flush_if;
    assign bus.stall_id_o       = stall_id;
    assign bus.hold_err_o       = hold_err_reg;
    assign bus.br_total_cnt_o   = cnt_val[0];
    assign bus.br_taken_cnt_o   = cnt_val[1];
endmodule
